// File: rtl/prio_grant_sched.sv
// prio_grant_sched: four-client arbiter for a shared datapath. It picks a client by
// fixed priority or round-robin, limits each tenure to HOLD_MAX cycles, puts one idle
// cycle after every tenure, and counts tenures started and tenures cut at the limit.
module prio_grant_sched #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_rr,
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    output logic [1:0]       grant_id,
    output logic             grant_valid,
    output logic [CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0] preempt_cnt
);

    localparam int unsigned HOLD_W = 8;
    localparam int unsigned REQ_N  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold;
    logic [1:0]        last;

    logic [1:0]        fp_pick_c;
    logic [1:0]        rr_pick_c;
    logic [1:0]        pick_c;
    logic              start_c;
    logic              release_c;
    logic              limit_c;
    logic              end_c;
    logic              preempt_c;

    // Fixed-priority decode: the highest-numbered requester wins.
    always_comb begin
        fp_pick_c = 2'd0;
        casez (req)
            4'b1???: fp_pick_c = 2'd3;
            4'b01??: fp_pick_c = 2'd2;
            4'b001?: fp_pick_c = 2'd1;
            4'b0001: fp_pick_c = 2'd0;
            default: fp_pick_c = 2'd0;
        endcase
    end

    // Round-robin search that starts one past the last owner and ends at the last owner.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        rr_pick_c = last;
        idx       = last;
        found     = 1'b0;
        for (int unsigned i = 1; i <= REQ_N; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                rr_pick_c = idx;
                found     = 1'b1;
            end
        end
    end

    // mode_rr is used only here, so it matters only at the IDLE arbitration edge.
    assign pick_c = mode_rr ? rr_pick_c : fp_pick_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_c) state_nxt = GRANT;
            GRANT:   if (end_c)   state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes. When the owner releases on the limit cycle, the tenure counts as a release.
    always_comb begin
        start_c   = (state == IDLE) && (req != 4'b0000);
        release_c = (state == GRANT) && !req[grant_id];
        limit_c   = (state == GRANT) && (hold == HOLD_W'(HOLD_MAX - 1));
        end_c     = release_c || limit_c;
        preempt_c = limit_c && !release_c;
    end

    // Registered grant outputs, hold counter, last-owner pointer and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= 4'b0000;
            grant_id    <= 2'd3;
            grant_valid <= 1'b0;
            grant_cnt   <= '0;
            preempt_cnt <= '0;
            hold        <= '0;
            last        <= 2'd3;
        end else if (start_c) begin
            grant       <= 4'(1) << pick_c;
            grant_id    <= pick_c;
            grant_valid <= 1'b1;
            hold        <= '0;
            grant_cnt   <= grant_cnt + CNT_W'(1);
        end else if (state == GRANT) begin
            hold <= hold + HOLD_W'(1);
            if (end_c) begin
                grant       <= 4'b0000;
                grant_valid <= 1'b0;
                last        <= grant_id;
            end
            if (preempt_c) begin
                preempt_cnt <= preempt_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prio_grant_sched.sv
// Directed bench for prio_grant_sched. It uses a default instance (HOLD_MAX=8, CNT_W=16)
// and a small instance (HOLD_MAX=1, CNT_W=4) for the hold-limit boundary and counter wrap.
// Inputs change and outputs are checked on the falling clock edge.
module tb_prio_grant_sched;

    logic        clk;
    logic        rst_n;

    logic        m_mode;
    logic [3:0]  m_req;
    logic [3:0]  m_grant;
    logic [1:0]  m_id;
    logic        m_valid;
    logic [15:0] m_gcnt;
    logic [15:0] m_pcnt;

    logic        s_mode;
    logic [3:0]  s_req;
    logic [3:0]  s_grant;
    logic [1:0]  s_id;
    logic        s_valid;
    logic [3:0]  s_gcnt;
    logic [3:0]  s_pcnt;

    int errors;
    int checks;

    logic [3:0] rr_exp [5];

    prio_grant_sched #(.HOLD_MAX(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_rr     (m_mode),
        .req         (m_req),
        .grant       (m_grant),
        .grant_id    (m_id),
        .grant_valid (m_valid),
        .grant_cnt   (m_gcnt),
        .preempt_cnt (m_pcnt)
    );

    prio_grant_sched #(.HOLD_MAX(1), .CNT_W(4)) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_rr     (s_mode),
        .req         (s_req),
        .grant       (s_grant),
        .grant_id    (s_id),
        .grant_valid (s_valid),
        .grant_cnt   (s_gcnt),
        .preempt_cnt (s_pcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        rst_n  = 1'b0;
        m_mode = 1'b0;
        m_req  = 4'b0000;
        s_mode = 1'b0;
        s_req  = 4'b0000;

        // Reset values
        repeat (2) nedge();
        check("rst_grant", 32'(m_grant), 32'h0);
        check("rst_id",    32'(m_id),    32'h3);
        check("rst_valid", 32'(m_valid), 32'h0);
        check("rst_gcnt",  32'(m_gcnt),  32'h0);
        check("rst_pcnt",  32'(m_pcnt),  32'h0);
        rst_n = 1'b1;

        // Fixed priority with req=0110: client 2 gets 8 cycles, 2 cycles off, then again
        nedge();
        m_req = 4'b0110;
        nedge();
        check("fp_grant_first", 32'(m_grant), 32'h4);
        check("fp_id",          32'(m_id),    32'h2);
        check("fp_valid",       32'(m_valid), 32'h1);
        check("fp_gcnt1",       32'(m_gcnt),  32'h1);
        for (int i = 1; i < 8; i++) begin
            nedge();
            check("fp_grant_hold", 32'(m_grant), 32'h4);
        end
        nedge();
        check("fp_gap1",      32'(m_grant), 32'h0);
        check("fp_gap_valid", 32'(m_valid), 32'h0);
        check("fp_pcnt1",     32'(m_pcnt),  32'h1);
        check("fp_id_hold",   32'(m_id),    32'h2);
        nedge();
        check("fp_gap2", 32'(m_grant), 32'h0);
        nedge();
        check("fp_regrant", 32'(m_grant), 32'h4);
        check("fp_gcnt2",   32'(m_gcnt),  32'h2);

        // Reset during a tenure clears everything without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant", 32'(m_grant), 32'h0);
        check("async_id",    32'(m_id),    32'h3);
        check("async_gcnt",  32'(m_gcnt),  32'h0);
        check("async_pcnt",  32'(m_pcnt),  32'h0);
        m_req = 4'b0000;
        nedge();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nedge();
            check("idle_grant", 32'(m_grant), 32'h0);
        end

        // Client 3 drops its request, giving a 3-cycle tenure with no preemption
        m_req = 4'b1000;
        nedge();
        check("rel_c1", 32'(m_grant), 32'h8);
        nedge();
        check("rel_c2", 32'(m_grant), 32'h8);
        nedge();
        check("rel_c3", 32'(m_grant), 32'h8);
        m_req = 4'b0000;
        nedge();
        check("rel_off",  32'(m_grant), 32'h0);
        check("rel_pcnt", 32'(m_pcnt),  32'h0);
        check("rel_gcnt", 32'(m_gcnt),  32'h1);
        check("rel_id",   32'(m_id),    32'h3);
        repeat (2) nedge();

        // Round-robin with all clients requesting from reset
        rst_n = 1'b0;
        nedge();
        rst_n  = 1'b1;
        m_mode = 1'b1;
        m_req  = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 8; c++) begin
                nedge();
                check("rr_grant", 32'(m_grant), 32'(rr_exp[t]));
            end
            if (t < 4) begin
                nedge();
                check("rr_gap1", 32'(m_grant), 32'h0);
                nedge();
                check("rr_gap2", 32'(m_grant), 32'h0);
            end
        end
        check("rr_gcnt", 32'(m_gcnt), 32'h5);
        check("rr_pcnt", 32'(m_pcnt), 32'h4);

        // A mode change during GRANT applies only at the next IDLE arbitration
        rst_n  = 1'b0;
        m_req  = 4'b0000;
        m_mode = 1'b0;
        nedge();
        rst_n = 1'b1;
        m_req = 4'b0011;
        nedge();
        check("ms_fp_pick", 32'(m_grant), 32'h2);
        m_mode = 1'b1;
        nedge();
        check("ms_tenure_kept", 32'(m_grant), 32'h2);
        check("ms_id",          32'(m_id),    32'h1);
        m_req = 4'b0001;
        nedge();
        check("ms_release", 32'(m_grant), 32'h0);
        m_req = 4'b0011;
        nedge();
        check("ms_idle", 32'(m_grant), 32'h0);
        nedge();
        check("ms_rr_pick", 32'(m_grant), 32'h1);
        check("ms_rr_id",   32'(m_id),    32'h0);

        // HOLD_MAX=1: release and hold limit in the same cycle count as a release
        rst_n = 1'b0;
        m_req = 4'b0000;
        nedge();
        rst_n = 1'b1;
        s_req = 4'b0001;
        nedge();
        check("h1_grant", 32'(s_grant), 32'h1);
        check("h1_gcnt",  32'(s_gcnt),  32'h1);
        s_req = 4'b0000;
        nedge();
        check("h1_off",  32'(s_grant), 32'h0);
        check("h1_pcnt", 32'(s_pcnt),  32'h0);

        // Counter wrap with CNT_W=4 and a 3-cycle period; tenure k starts at edge 3k-2
        rst_n = 1'b0;
        nedge();
        rst_n = 1'b1;
        s_req = 4'b0001;
        repeat (46) nedge();
        check("wrap_gcnt16", 32'(s_gcnt),  32'h0);
        check("wrap_pcnt15", 32'(s_pcnt),  32'hf);
        check("wrap_grant",  32'(s_grant), 32'h1);
        repeat (3) nedge();
        check("wrap_gcnt17", 32'(s_gcnt),  32'h1);
        check("wrap_grant2", 32'(s_grant), 32'h1);
        s_req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
